uart_rx_flow_fifo: RTL and testbench



---
 rtl/uart_rx_flow_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_rx_flow_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_flow_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_flow_fifo
// Brief    : RX byte FIFO with registered output stage, RTS output gating and
//            hysteretic CTS generation. UART_FLOW_STATS_EN adds drop/peak stats.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_flow_fifo #(
    parameter int DEPTH      = 16,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 byte_in_data,
    input  logic                       byte_in_valid,
    output logic                       byte_in_ready,
    output logic [7:0]                 byte_out_data,
    output logic                       byte_out_valid,
    input  logic                       byte_out_ready,
    input  logic                       rts_n_in,
    output logic                       cts_n_out,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fill_level
`ifdef UART_FLOW_STATS_EN
    ,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     peak_level
`endif
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    typedef enum logic [0:0] {
        CTS_WITHHELD = 1'b0,
        CTS_GRANTED  = 1'b1
    } cts_state_t;

    logic [7:0]      r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] w_rd_ptr_nxt1;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_next;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_overflow;
    logic            r_cts_n;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_load;
    logic            w_stored_ok;
    logic [7:0]      w_stored_data;
    logic            w_have_next;
    logic [7:0]      w_next_data;
    cts_state_t      r_cts_state;
    cts_state_t      w_cts_state_next;

    always_comb begin
        w_full        = (r_count == c_CW'(DEPTH));
        w_pop         = r_out_valid & byte_out_ready;
        w_push        = byte_in_valid & (~w_full | w_pop);
        w_drop        = byte_in_valid & w_full & ~w_pop;
        w_count_next  = r_count + c_CW'(w_push) - c_CW'(w_pop);
        w_rd_ptr_nxt1 = r_rd_ptr + c_PW'(1);
        // The count includes the presented byte, so the next head sits one
        // slot past rd_ptr when the current one is being popped.
        w_load        = (~r_out_valid | w_pop) & ~rts_n_in;
        w_stored_ok   = r_out_valid ? (r_count > c_CW'(1)) : (r_count != '0);
        w_stored_data = r_out_valid ? r_mem[w_rd_ptr_nxt1] : r_mem[r_rd_ptr];
        w_have_next   = w_stored_ok | w_push;
        w_next_data   = w_stored_ok ? w_stored_data : byte_in_data;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt1;
            if (w_drop) r_overflow <= 1'b1;
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else if (w_load) begin
            r_out_valid <= w_have_next;
            if (w_have_next) r_out_data <= w_next_data;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cts_state <= CTS_WITHHELD;
            r_cts_n     <= 1'b1;
        end else begin
            r_cts_state <= w_cts_state_next;
            r_cts_n     <= (r_cts_state == CTS_WITHHELD);
        end
    end

    always_comb begin
        w_cts_state_next = r_cts_state;
        case (r_cts_state)
            CTS_GRANTED:  if (w_count_next >= c_CW'(HIGH_WATER)) w_cts_state_next = CTS_WITHHELD;
            CTS_WITHHELD: if (w_count_next <= c_CW'(LOW_WATER))  w_cts_state_next = CTS_GRANTED;
            default:      w_cts_state_next = CTS_WITHHELD;
        endcase
    end

`ifdef UART_FLOW_STATS_EN
    logic [15:0]     r_drop_count;
    logic [c_CW-1:0] r_peak_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_count <= 16'h0000;
            r_peak_level <= '0;
        end else begin
            if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
            if (w_count_next > r_peak_level) r_peak_level <= w_count_next;
        end
    end

    assign drop_count = r_drop_count;
    assign peak_level = r_peak_level;
`endif

    assign byte_in_ready  = 1'b1;
    assign byte_out_data  = r_out_data;
    assign byte_out_valid = r_out_valid;
    assign cts_n_out      = r_cts_n;
    assign overflow       = r_overflow;
    assign fill_level     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_flow_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_flow_fifo
// Brief    : Queue-model bench for uart_rx_flow_fifo with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_flow_fifo;

    localparam int DEPTH      = 16;
    localparam int HIGH_WATER = 12;
    localparam int LOW_WATER  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in_data = 8'h00;
    logic       byte_in_valid = 1'b0;
    logic       byte_in_ready;
    logic [7:0] byte_out_data;
    logic       byte_out_valid;
    logic       byte_out_ready = 1'b0;
    logic       rts_n_in = 1'b0;
    logic       cts_n_out;
    logic       overflow;
    logic [4:0] fill_level;
`ifdef UART_FLOW_STATS_EN
    logic [15:0] drop_count;
    logic [4:0]  peak_level;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Spec-level model: queue of held bytes plus the presented-byte flag.
    logic [7:0] mq[$];
    bit         m_valid    = 1'b0;
    logic [7:0] m_data     = 8'h00;
    bit         m_ovf      = 1'b0;
    bit         m_granted  = 1'b0;
    bit         m_cts_n    = 1'b1;
    int         m_drops    = 0;
    int         m_peak     = 0;

    uart_rx_flow_fifo #(
        .DEPTH(DEPTH), .HIGH_WATER(HIGH_WATER), .LOW_WATER(LOW_WATER)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_in_data(byte_in_data), .byte_in_valid(byte_in_valid),
        .byte_in_ready(byte_in_ready),
        .byte_out_data(byte_out_data), .byte_out_valid(byte_out_valid),
        .byte_out_ready(byte_out_ready),
        .rts_n_in(rts_n_in), .cts_n_out(cts_n_out),
        .overflow(overflow), .fill_level(fill_level)
`ifdef UART_FLOW_STATS_EN
        , .drop_count(drop_count), .peak_level(peak_level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop;
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0; m_data = 8'h00; m_ovf = 1'b0;
            m_granted = 1'b0; m_cts_n = 1'b1; m_drops = 0; m_peak = 0;
        end else begin
            pop = m_valid && byte_out_ready;
            m_cts_n = !m_granted;
            if (pop) void'(mq.pop_front());
            if (byte_in_valid) begin
                if (mq.size() < DEPTH) mq.push_back(byte_in_data);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (!(m_valid && !pop)) begin
                if (!rts_n_in && mq.size() > 0) begin
                    m_valid = 1'b1; m_data = mq[0];
                end else m_valid = 1'b0;
            end
            if (m_granted && mq.size() >= HIGH_WATER) m_granted = 1'b0;
            else if (!m_granted && mq.size() <= LOW_WATER) m_granted = 1'b1;
            if (mq.size() > m_peak) m_peak = mq.size();
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        byte_in_valid = v;
        byte_in_data  = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(byte_out_valid), 32'(m_valid));
            if (m_valid) check("data", 32'(byte_out_data), 32'(m_data));
            check("fill", 32'(fill_level), 32'(mq.size()));
            check("cts_n", 32'(cts_n_out), 32'(m_cts_n));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("in_ready", 32'(byte_in_ready), 32'd1);
`ifdef UART_FLOW_STATS_EN
            check("drop_count", 32'(drop_count), 32'(m_drops));
            check("peak_level", 32'(peak_level), 32'(m_peak));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] lastb;
        lastb = 8'h00;

        // Reset then idle
        rst_n = 1'b0; rts_n_in = 1'b0; byte_out_ready = 1'b0;
        repeat (3) step(1'b0, 8'h00);
        chk_en = 1'b1;
        check("rst_cts_n", 32'(cts_n_out), 32'd1);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_valid", 32'(byte_out_valid), 32'd0);
        check("rst_data", 32'(byte_out_data), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 8'h00);
        check("cts_one_after", 32'(cts_n_out), 32'd1);
        step(1'b0, 8'h00);
        check("cts_two_after", 32'(cts_n_out), 32'd0);

        // Two bytes straight through
        byte_out_ready = 1'b1;
        step(1'b1, 8'hA5);
        check("first_valid", 32'(byte_out_valid), 32'd1);
        check("first_data", 32'(byte_out_data), 32'hA5);
        step(1'b1, 8'h3C);
        check("second_data", 32'(byte_out_data), 32'h3C);
        step(1'b0, 8'h00);
        check("pass_fill0", 32'(fill_level), 32'd0);

        // RTS withheld fill to HIGH_WATER, then drain
        rts_n_in = 1'b1; byte_out_ready = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b1, 8'(i));
        check("hw_fill", 32'(fill_level), 32'd12);
        check("hw_valid", 32'(byte_out_valid), 32'd0);
        step(1'b0, 8'h00);
        check("hw_cts_n", 32'(cts_n_out), 32'd1);
        rts_n_in = 1'b0; byte_out_ready = 1'b1;
        step(1'b0, 8'h00);
        check("drain_b0", 32'(byte_out_data), 32'h00);
        step(1'b0, 8'h00);
        check("drain_b1", 32'(byte_out_data), 32'h01);
        for (int i = 0; i < 20 && fill_level != 0; i++) step(1'b0, 8'h00);
        check("drain_fill", 32'(fill_level), 32'd0);
        check("drain_cts_n", 32'(cts_n_out), 32'd0);

        // Overflow at full
        rts_n_in = 1'b1; byte_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i));
        check("full_fill", 32'(fill_level), 32'd16);
        step(1'b1, 8'hEE);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_fill", 32'(fill_level), 32'd16);
`ifdef UART_FLOW_STATS_EN
        check("ovf_drops", 32'(drop_count), 32'd1);
        check("ovf_peak", 32'(peak_level), 32'd16);
`endif

        // Mid-operation reset
        rst_n = 1'b0;
        step(1'b0, 8'h00);
        check("mid_rst_fill", 32'(fill_level), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_cts", 32'(cts_n_out), 32'd1);
        rst_n = 1'b1;

        // Push and pop together at full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i));
        rts_n_in = 1'b0;
        step(1'b0, 8'h00);
        check("full_head", 32'(byte_out_data), 32'h20);
        byte_out_ready = 1'b1;
        step(1'b1, 8'h77);
        check("pp_fill", 32'(fill_level), 32'd16);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_next", 32'(byte_out_data), 32'h21);
        for (int i = 0; i < 40 && fill_level != 0; i++) begin
            if (fill_level == 1) lastb = byte_out_data;
            step(1'b0, 8'h00);
        end
        check("pp_last", 32'(lastb), 32'h77);

        // Presented byte holds across RTS deassertion
        byte_out_ready = 1'b0;
        step(1'b1, 8'h51);
        step(1'b1, 8'h52);
        rts_n_in = 1'b1;
        repeat (3) step(1'b0, 8'h00);
        check("hold_valid", 32'(byte_out_valid), 32'd1);
        check("hold_data", 32'(byte_out_data), 32'h51);
        byte_out_ready = 1'b1;
        step(1'b0, 8'h00);
        check("gate_valid", 32'(byte_out_valid), 32'd0);
        check("gate_fill", 32'(fill_level), 32'd1);
        step(1'b0, 8'h00);
        check("gate_still", 32'(byte_out_valid), 32'd0);
        rts_n_in = 1'b0;
        step(1'b0, 8'h00);
        check("regate_data", 32'(byte_out_data), 32'h52);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check("end_fill", 32'(fill_level), 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
